// File: rtl/sample_pkg.sv
// -----------------------------------------------------------------------------
// sample_pkg
// Shared types for the audio sample path: the stereo sample word passed
// between the I2S receiver, the effects chain and the I2S transmitter, plus
// the I2S receiver state encoding.
//   SAMPLE_BITS    : bits per audio channel word (24)
//   I2S_SLOT_BITS  : nominal sclk periods per channel slot (32)
//   sample_t       : packed stereo sample {lc, rc}, both signed SAMPLE_BITS
//   i2s_rx_state_e : receiver framing state (SYNC, LEFT, RIGHT)
// -----------------------------------------------------------------------------
package sample_pkg;

  localparam int SAMPLE_BITS   = 24;
  localparam int I2S_SLOT_BITS = 32;

  typedef struct packed {
    logic signed [SAMPLE_BITS-1:0] lc;
    logic signed [SAMPLE_BITS-1:0] rc;
  } sample_t;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_LEFT,
    ST_RIGHT
  } i2s_rx_state_e;

endpackage

// File: rtl/i2s_in_sync.sv
// -----------------------------------------------------------------------------
// i2s_in_sync
// Brings the codec's sclk, lrck and sdi into the clk domain through
// SYNC_STAGES flops each and detects rising edges of the synced sclk.
// The edge strobe and the two data samples leave through one more register
// so that pe, lrck_s and sdi_s are always aligned to the same sclk rise.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   sclk, lrck, sdi : raw codec inputs (asynchronous to clk)
//   pe     : one-clk strobe per sclk rising edge
//   lrck_s : lrck value belonging to that edge
//   sdi_s  : sdi value belonging to that edge
// -----------------------------------------------------------------------------
module i2s_in_sync #(
  parameter int SYNC_STAGES = 2   // legal values: 2 or 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic lrck,
  input  logic sdi,
  output logic pe,
  output logic lrck_s,
  output logic sdi_s
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sclk_d;

  // NOTE: all sequential state below uses non-blocking assignments so every
  // flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      lrck_sync <= '0;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
      pe        <= 1'b0;
      lrck_s    <= 1'b0;
      sdi_s     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      // lrck/sdi travel through the same depth as sclk, so they are stable
      // (they change on the falling sclk edge) when the rise is seen.
      pe        <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
      lrck_s    <= lrck_sync[SYNC_STAGES-1];
      sdi_s     <= sdi_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// -----------------------------------------------------------------------------
// i2s_rx
// I2S receive deserializer for the codec ADC path. Reassembles 24-bit left and
// right words (MSB first, standard one-bit I2S delay) and emits one stereo
// sample per complete left+right frame with a single-cycle vld strobe.
// Optional build macro: I2S_RX_SLOT_CHECK_EN enables slot-length checking and
// the err pulse; without it err is tied 0.
// Ports:
//   clk, rst_n : system clock (>= 4x sclk), asynchronous active-low reset
//   sclk, lrck, sdi : codec serial clock, word select (0=left), serial data
//   data : registered stereo sample (sample_t), changes only with vld
//   vld  : one-clk pulse when data is updated
//   err  : one-clk pulse on slot-length violation (macro builds only)
// -----------------------------------------------------------------------------
module i2s_rx
  import sample_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SLOT_BITS   = I2S_SLOT_BITS
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    sclk,
  input  logic    lrck,
  input  logic    sdi,
  output sample_t data,
  output logic    vld,
  output logic    err
);

  localparam logic [5:0] CNT_MAX  = 6'(SLOT_BITS);
  localparam logic [5:0] CNT_WORD = 6'(SAMPLE_BITS);
  localparam logic [5:0] CNT_LAST = 6'(SAMPLE_BITS - 1);

  logic pe;
  logic lrck_s;
  logic sdi_s;

  i2s_in_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclk   (sclk),
    .lrck   (lrck),
    .sdi    (sdi),
    .pe     (pe),
    .lrck_s (lrck_s),
    .sdi_s  (sdi_s)
  );

  i2s_rx_state_e          state;
  logic                   lrck_q;
  logic [5:0]             bit_cnt;
  // Only the first 23 bits need storing; the 24th is appended directly from
  // sdi_s on the completing edge.
  logic [SAMPLE_BITS-2:0] shift;
  logic [SAMPLE_BITS-1:0] left_hold;
  logic                   l_ok;
  logic                   pend;
  logic [SAMPLE_BITS-1:0] pend_rc;

  logic                   boundary;
  logic [SAMPLE_BITS-1:0] word;
  logic                   slot_bad;

  assign boundary = pe && (lrck_s != lrck_q);
  assign word     = {shift, sdi_s};

`ifdef I2S_RX_SLOT_CHECK_EN
  // A correct slot sees SLOT_BITS-1 non-boundary edges between boundaries.
  assign slot_bad = boundary && (state != ST_SYNC) && (bit_cnt != CNT_MAX - 6'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= slot_bad;
    end
  end
`else
  assign slot_bad = 1'b0;
  assign err      = 1'b0;
`endif

  // NOTE: the output and holding registers are reset along with the control
  // state, since data must read 0 from the moment reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SYNC;
      lrck_q    <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
      left_hold <= '0;
      l_ok      <= 1'b0;
      pend      <= 1'b0;
      pend_rc   <= '0;
      data      <= '0;
      vld       <= 1'b0;
    end else begin
      vld <= 1'b0;

      // Output stage: publish the frame one cycle after the right word lands.
      if (pend) begin
        data <= '{lc: left_hold, rc: pend_rc};
        vld  <= 1'b1;
        pend <= 1'b0;
      end

      if (pe) begin
        lrck_q <= lrck_s;
        if (boundary) begin
          // The bit on a boundary edge is the old slot's last bit: dropped.
          bit_cnt <= '0;
          if (slot_bad) begin
            state <= ST_SYNC;
            l_ok  <= 1'b0;
          end else begin
            case (state)
              ST_SYNC: begin
                if (!lrck_s) begin
                  state <= ST_LEFT;
                  l_ok  <= 1'b0;
                end
              end
              ST_LEFT: begin
                if (lrck_s) state <= l_ok ? ST_RIGHT : ST_SYNC;
              end
              ST_RIGHT: begin
                if (!lrck_s) state <= ST_LEFT;
              end
              default: state <= ST_SYNC;
            endcase
          end
        end else begin
          if (bit_cnt < CNT_WORD) shift <= word[SAMPLE_BITS-2:0];
          if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt == CNT_LAST) begin
            if (state == ST_LEFT) begin
              left_hold <= word;
              l_ok      <= 1'b1;
            end else if (state == ST_RIGHT && l_ok) begin
              pend_rc <= word;
              pend    <= 1'b1;
              l_ok    <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx
// Self-checking bench for i2s_rx. An I2S transmitter model drives sclk at
// clk/8; expected stereo samples are queued as frames are sent and compared
// as vld pulses arrive. Expectations follow I2S_RX_SLOT_CHECK_EN when defined.
// -----------------------------------------------------------------------------
module tb_i2s_rx;
  import sample_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int SLOT        = 32;
`ifdef I2S_RX_SLOT_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic    clk   = 1'b0;
  logic    rst_n = 1'b0;
  logic    sclk  = 1'b0;
  logic    lrck  = 1'b0;
  logic    sdi   = 1'b0;
  sample_t data;
  logic    vld;
  logic    err;

  i2s_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .SLOT_BITS   (SLOT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sclk  (sclk),
    .lrck  (lrck),
    .sdi   (sdi),
    .data  (data),
    .vld   (vld),
    .err   (err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          t_e0     = 0;
  int          err_cnt  = 0;
  int          vld_cnt  = 0;
  logic [47:0] sb[$];
  logic        last_bit = 1'b0;
  logic [47:0] prev_data = '0;
  logic        prev_rst  = 1'b0;
  logic        prev_vld  = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each rising clk edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst_n && prev_rst && !vld) check("data_hold", data, prev_data);
    if (vld) begin
      vld_cnt++;
      check("vld_single", prev_vld, 1'b0);
      check("vld_latency", cyc - t_e0, SYNC_STAGES + 2);
      check("vld_expected", sb.size() > 0, 1'b1);
      if (sb.size() > 0) check("sample", {data.lc, data.rc}, sb.pop_front());
    end
    if (err) err_cnt++;
    prev_data = {data.lc, data.rc};
    prev_rst  = rst_n;
    prev_vld  = vld;
  end

  function automatic logic slot_bit(input logic [23:0] w, input int k);
    logic [23:0] v;
    v = w;
    return (k < 24) ? v[23 - k] : 1'b0;
  endfunction

  // One sclk period: falling edge with new lrck/sdi, rise four clks later.
  task automatic period(input logic ws, input logic d, input bit mark, input bit do_rst);
    sclk = 1'b0;
    lrck = ws;
    sdi  = d;
    if (do_rst) begin
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_data", {data.lc, data.rc}, 48'h0);
      check("rst_async_vld", vld, 1'b0);
      check("rst_async_err", err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    sclk = 1'b1;
    if (mark) t_e0 = cyc + 1;
    repeat (4) @(negedge clk);
  endtask

  // A slot of n periods: the first carries the previous slot's last bit.
  task automatic send_slot(input logic ch, input logic [23:0] w, input int n, input int rst_at);
    period(ch, last_bit, 1'b0, rst_at == 0);
    for (int k = 0; k < n - 1; k++)
      period(ch, slot_bit(w, k), ch && (k == 23), rst_at == k + 1);
    last_bit = slot_bit(w, n - 1);
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                            input int nl, input int nr, input bit expect_out);
    if (expect_out) sb.push_back({l, r});
    send_slot(1'b0, l, nl, -1);
    send_slot(1'b1, r, nr, -1);
  endtask

  initial begin
    int e0;
    int v0;
    repeat (3) @(negedge clk);
    check("reset_data", {data.lc, data.rc}, 48'h0);
    check("reset_vld", vld, 1'b0);
    check("reset_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal frame, preceded by a right slot so the left boundary is seen.
    send_slot(1'b1, 24'h0, SLOT, -1);
    send_frame(24'h123456, 24'hABCDEF, SLOT, SLOT, 1'b1);
    check("nominal_vld_count", vld_cnt, 1);

    // Reset released mid right slot, then two good frames.
    send_slot(1'b0, 24'h555555, SLOT, -1);
    send_slot(1'b1, 24'hAAAAAA, SLOT, 10);
    send_frame(24'h000001, 24'h800000, SLOT, SLOT, 1'b1);
    send_frame(24'h7FFFFF, 24'hFFFFFF, SLOT, SLOT, 1'b1);
    check("midframe_vld_count", vld_cnt, 3);

    // Short left slot: dropped, then recovery.
    e0 = err_cnt;
    v0 = vld_cnt;
    send_frame(24'h111111, 24'h222222, 20, SLOT, 1'b0);
    check("short_err", err_cnt - e0, CHK);
    check("short_no_vld", vld_cnt - v0, 0);
    send_frame(24'h333333, 24'h444444, SLOT, SLOT, 1'b1);

    // 31-bit left slot: flagged and dropped only with slot checking.
    e0 = err_cnt;
    send_frame(24'h5A5A5A, 24'hA5A5A5, 31, SLOT, CHK == 0);
    check("slot31_err", err_cnt - e0, CHK);
    send_frame(24'h0F0F0F, 24'hF0F0F0, SLOT, SLOT, 1'b1);

    // Reset at the 12th left bit; the rest of that frame is not emitted.
    v0 = vld_cnt;
    send_slot(1'b0, 24'h666666, SLOT, 12);
    send_slot(1'b1, 24'h777777, SLOT, -1);
    check("rstmid_no_vld", vld_cnt - v0, 0);
    send_frame(24'h123123, 24'h321321, SLOT, SLOT, 1'b1);

    // Back-to-back frames with incrementing values.
    e0 = err_cnt;
    v0 = vld_cnt;
    for (int i = 0; i < 100; i++)
      send_frame(24'h100000 + 24'(i), 24'hF00000 + 24'(3 * i), SLOT, SLOT, 1'b1);
    check("b2b_vld_count", vld_cnt - v0, 100);
    check("b2b_err", err_cnt - e0, 0);

    repeat (50) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
